// File: rtl/dbg_halt_ctrl.sv
// dbg_halt_ctrl: debug halt sequencer sitting between the halt/ack CSR and the core.
//   RUN -> DRAIN (stall, wait for idle or timeout) -> HALTED (dbg_mode) -> RESUME (settle) -> RUN.
//   All outputs are registered. Reset is synchronous, active-high.
// Optional feature macro: DBG_HALT_STEP_EN
//   Defined     : single-step support (HALTED --step_req--> STEP --instr_retire--> DRAIN).
//   Not defined : STEP is unreachable; step_req and instr_retire are ignored.
module dbg_halt_ctrl #(
    parameter int DRAIN_TIMEOUT = 16,  // max DRAIN cycles before a forced halt (>=1)
    parameter int RESUME_DLY    = 2    // cycles core_stall stays high after dbg_mode drops (>=1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       halt_req,
    input  logic       core_idle,
    input  logic       err_clr,
    input  logic       step_req,
    input  logic       instr_retire,
    output logic       core_stall,
    output logic       dbg_mode,
    output logic       timeout_err,
    output logic [2:0] state_o
);

    // Shared drain/resume counter sized for the larger of the two bounds.
    localparam int MAX_CNT = (DRAIN_TIMEOUT > RESUME_DLY) ? DRAIN_TIMEOUT : RESUME_DLY;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RESUME_LAST = CNT_W'(RESUME_DLY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_DRAIN  = 3'd1,
        ST_HALTED = 3'd2,
        ST_RESUME = 3'd3,
        ST_STEP   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

`ifndef DBG_HALT_STEP_EN
    // Step inputs are kept on the port list but have no function in this build.
    logic unused_step;
    assign unused_step = step_req ^ instr_retire;
`endif

    assign state_o = state;

    // Sequencer: state, counter and registered outputs all update together from one block.
    // NOTE: sequential state uses non-blocking assignments so every register here sees the
    //       pre-edge values of the others; blocking assignments would make order matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            cnt         <= '0;
            core_stall  <= 1'b0;
            dbg_mode    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Clear first; a timeout later in this block overrides it (set wins).
            if (err_clr) begin
                timeout_err <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (halt_req) begin
                        state      <= ST_DRAIN;
                        cnt        <= '0;
                        core_stall <= 1'b1;
                        dbg_mode   <= 1'b0;
                    end
                end

                ST_DRAIN: begin
                    cnt <= cnt + CNT_ONE;
                    if (!halt_req) begin
                        // Request withdrawn before the core drained: abort silently.
                        state      <= ST_RUN;
                        core_stall <= 1'b0;
                        dbg_mode   <= 1'b0;
                    end else if (core_idle) begin
                        // Idle beats timeout when both occur in the same cycle.
                        state      <= ST_HALTED;
                        core_stall <= 1'b1;
                        dbg_mode   <= 1'b1;
                    end else if (cnt == DRAIN_LAST) begin
                        state       <= ST_HALTED;
                        core_stall  <= 1'b1;
                        dbg_mode    <= 1'b1;
                        timeout_err <= 1'b1;
                    end
                end

                ST_HALTED: begin
                    if (!halt_req) begin
                        // Resume has priority over a simultaneous step request.
                        state      <= ST_RESUME;
                        cnt        <= '0;
                        core_stall <= 1'b1;
                        dbg_mode   <= 1'b0;
`ifdef DBG_HALT_STEP_EN
                    end else if (step_req) begin
                        state      <= ST_STEP;
                        core_stall <= 1'b0;
                        dbg_mode   <= 1'b0;
`endif
                    end
                end

                ST_RESUME: begin
                    cnt <= cnt + CNT_ONE;
                    if (halt_req) begin
                        // Core is still stalled and idle, so re-halt without draining.
                        state      <= ST_HALTED;
                        core_stall <= 1'b1;
                        dbg_mode   <= 1'b1;
                    end else if (cnt == RESUME_LAST) begin
                        state      <= ST_RUN;
                        core_stall <= 1'b0;
                        dbg_mode   <= 1'b0;
                    end
                end

`ifdef DBG_HALT_STEP_EN
                ST_STEP: begin
                    if (!halt_req) begin
                        state      <= ST_RUN;
                        core_stall <= 1'b0;
                        dbg_mode   <= 1'b0;
                    end else if (instr_retire) begin
                        // One instruction done: drain again under the normal rules.
                        state      <= ST_DRAIN;
                        cnt        <= '0;
                        core_stall <= 1'b1;
                        dbg_mode   <= 1'b0;
                    end
                end
`endif

                default: begin
                    // Unused encodings (and STEP when stepping is compiled out) recover to RUN.
                    state      <= ST_RUN;
                    cnt        <= '0;
                    core_stall <= 1'b0;
                    dbg_mode   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_halt_ctrl.sv
// Self-checking bench for dbg_halt_ctrl: directed sequence, expected outputs queued as a
// scoreboard before each clock edge and compared one time step after the edge.
module tb_dbg_halt_ctrl;

    localparam int DRAIN_TIMEOUT = 16;
    localparam int RESUME_DLY    = 2;

    localparam logic [2:0] S_RUN    = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_HALTED = 3'd2;
    localparam logic [2:0] S_RESUME = 3'd3;
    localparam logic [2:0] S_STEP   = 3'd4;

    logic       clk = 1'b0;
    logic       rst;
    logic       halt_req;
    logic       core_idle;
    logic       err_clr;
    logic       step_req;
    logic       instr_retire;
    logic       core_stall;
    logic       dbg_mode;
    logic       timeout_err;
    logic [2:0] state_o;

    typedef struct {
        string      tag;
        logic [5:0] val;  // {state, stall, dbg, err}
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    dbg_halt_ctrl #(
        .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
        .RESUME_DLY   (RESUME_DLY)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt_req    (halt_req),
        .core_idle   (core_idle),
        .err_clr     (err_clr),
        .step_req    (step_req),
        .instr_retire(instr_retire),
        .core_stall  (core_stall),
        .dbg_mode    (dbg_mode),
        .timeout_err (timeout_err),
        .state_o     (state_o)
    );

    always #5 clk = ~clk;

    // Queue the outputs expected after the next rising edge.
    task automatic expect_out(input string tag, input logic [2:0] st, input logic stall,
                              input logic dbg, input logic err);
        exp_t e;
        e.tag = tag;
        e.val = {st, stall, dbg, err};
        sb.push_back(e);
    endtask

    // Advance one edge, then pop the oldest expectation and compare.
    task automatic tick_check();
        exp_t       e;
        logic [5:0] obs;
        @(posedge clk);
        #1;
        obs = {state_o, core_stall, dbg_mode, timeout_err};
        tests_run++;
        if (sb.size() == 0) begin
            tests_failed++;
            $display("FAIL scoreboard_empty: no expectation queued for this edge");
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                tests_failed++;
                $error("FAIL %s: observed state=%0d stall=%b dbg=%b err=%b, expected state=%0d stall=%b dbg=%b err=%b",
                       e.tag, obs[5:3], obs[2], obs[1], obs[0],
                       e.val[5:3], e.val[2], e.val[1], e.val[0]);
            end
        end
    endtask

    // Convenience: queue one expectation and consume it at the next edge.
    task automatic step_exp(input string tag, input logic [2:0] st, input logic stall,
                            input logic dbg, input logic err);
        expect_out(tag, st, stall, dbg, err);
        tick_check();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; halt_req = 1'b0; core_idle = 1'b0;
        err_clr = 1'b0; step_req = 1'b0; instr_retire = 1'b0;
        @(negedge clk);

        // Reset state held over two cycles.
        step_exp("reset_c1", S_RUN, 1'b0, 1'b0, 1'b0);
        step_exp("reset_c2", S_RUN, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Halt with core already idle: stall after edge k, dbg_mode after k+1.
        core_idle = 1'b1; halt_req = 1'b1;
        expect_out("halt_idle_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        expect_out("halt_idle_halted", S_HALTED, 1'b1, 1'b1, 1'b0);
        tick_check();
        tick_check();
        step_exp("halted_hold", S_HALTED, 1'b1, 1'b1, 1'b0);

        // Reset while HALTED aborts to RUN at once.
        rst = 1'b1;
        step_exp("rst_in_halted", S_RUN, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step_exp("rehalt_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        step_exp("rehalt_halted", S_HALTED, 1'b1, 1'b1, 1'b0);

        // Resume: dbg drops after edge m, stall drops after m+RESUME_DLY.
        halt_req = 1'b0;
        expect_out("resume_c1", S_RESUME, 1'b1, 1'b0, 1'b0);
        expect_out("resume_c2", S_RESUME, 1'b1, 1'b0, 1'b0);
        expect_out("resume_done", S_RUN, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < RESUME_DLY + 1; i++) tick_check();

        // Re-raise halt_req during RESUME goes straight back to HALTED.
        halt_req = 1'b1;
        step_exp("halt2_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        step_exp("halt2_halted", S_HALTED, 1'b1, 1'b1, 1'b0);
        halt_req = 1'b0;
        step_exp("resume_abort_c1", S_RESUME, 1'b1, 1'b0, 1'b0);
        halt_req = 1'b1;
        step_exp("resume_rehalt", S_HALTED, 1'b1, 1'b1, 1'b0);

        // Back to RUN for timeout tests.
        halt_req = 1'b0;
        step_exp("ret_run_c1", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("ret_run_c2", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("ret_run_c3", S_RUN, 1'b0, 1'b0, 1'b0);

        // Drain timeout: HALTED after DRAIN_TIMEOUT DRAIN cycles with error set.
        core_idle = 1'b0; halt_req = 1'b1;
        step_exp("to_enter_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < DRAIN_TIMEOUT; i++) step_exp("to_in_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        step_exp("to_halted", S_HALTED, 1'b1, 1'b1, 1'b1);
        step_exp("to_err_sticky", S_HALTED, 1'b1, 1'b1, 1'b1);
        err_clr = 1'b1;
        step_exp("err_clr", S_HALTED, 1'b1, 1'b1, 1'b0);
        err_clr = 1'b0;

        // Timeout and err_clr in the same cycle: set wins.
        halt_req = 1'b0;
        step_exp("sw_resume_c1", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("sw_resume_c2", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("sw_run", S_RUN, 1'b0, 1'b0, 1'b0);
        halt_req = 1'b1;
        step_exp("sw_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < DRAIN_TIMEOUT; i++) step_exp("sw_in_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        err_clr = 1'b1;
        step_exp("set_wins", S_HALTED, 1'b1, 1'b1, 1'b1);
        step_exp("clr_after_set", S_HALTED, 1'b1, 1'b1, 1'b0);
        err_clr = 1'b0;

        // Idle rising on the last DRAIN cycle: halt without error.
        halt_req = 1'b0;
        step_exp("id_resume_c1", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("id_resume_c2", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("id_run", S_RUN, 1'b0, 1'b0, 1'b0);
        halt_req = 1'b1;
        step_exp("id_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < DRAIN_TIMEOUT; i++) step_exp("id_in_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        core_idle = 1'b1;
        step_exp("idle_beats_timeout", S_HALTED, 1'b1, 1'b1, 1'b0);

        // Drain abort after 3 DRAIN cycles with core busy.
        halt_req = 1'b0; core_idle = 1'b0;
        step_exp("ab_resume_c1", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("ab_resume_c2", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("ab_run", S_RUN, 1'b0, 1'b0, 1'b0);
        halt_req = 1'b1;
        step_exp("ab_drain_c1", S_DRAIN, 1'b1, 1'b0, 1'b0);
        step_exp("ab_drain_c2", S_DRAIN, 1'b1, 1'b0, 1'b0);
        step_exp("ab_drain_c3", S_DRAIN, 1'b1, 1'b0, 1'b0);
        halt_req = 1'b0;
        step_exp("drain_abort", S_RUN, 1'b0, 1'b0, 1'b0);

        // step_req outside HALTED is ignored.
        step_req = 1'b1;
        step_exp("step_in_run", S_RUN, 1'b0, 1'b0, 1'b0);
        step_req = 1'b0;

        // Single step from HALTED.
        core_idle = 1'b1; halt_req = 1'b1;
        step_exp("st_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        step_exp("st_halted", S_HALTED, 1'b1, 1'b1, 1'b0);
        step_req = 1'b1;
`ifdef DBG_HALT_STEP_EN
        step_exp("step_enter", S_STEP, 1'b0, 1'b0, 1'b0);
        step_req = 1'b0;
        for (int i = 0; i < 3; i++) step_exp("step_wait", S_STEP, 1'b0, 1'b0, 1'b0);
        instr_retire = 1'b1;
        step_exp("step_retire_drain", S_DRAIN, 1'b1, 1'b0, 1'b0);
        instr_retire = 1'b0;
        step_exp("step_rehalt", S_HALTED, 1'b1, 1'b1, 1'b0);
`else
        step_exp("step_disabled", S_HALTED, 1'b1, 1'b1, 1'b0);
        step_req = 1'b0;
        for (int i = 0; i < 3; i++) step_exp("step_dis_wait", S_HALTED, 1'b1, 1'b1, 1'b0);
        instr_retire = 1'b1;
        step_exp("retire_ignored", S_HALTED, 1'b1, 1'b1, 1'b0);
        instr_retire = 1'b0;
        step_exp("still_halted", S_HALTED, 1'b1, 1'b1, 1'b0);
`endif

        // Resume beats a simultaneous step request.
        halt_req = 1'b0; step_req = 1'b1;
        step_exp("resume_beats_step", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_req = 1'b0;
        step_exp("end_resume_c2", S_RESUME, 1'b1, 1'b0, 1'b0);
        step_exp("end_run", S_RUN, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
